// File: rtl/xor_pkg.sv
// Shared types, LFSR taps and helper functions for the XOR keystream unit.
package xor_pkg;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_e;

  localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;

  function automatic logic [31:0] taps_for(input int unsigned width);
    case (width)
      8:       return TAPS_8;
      16:      return TAPS_16;
      32:      return TAPS_32;
      default: return 32'h0;
    endcase
  endfunction

  // Right-shifting Galois step; operands are zero-extended to 32 bits.
  function automatic logic [31:0] lfsr_step(input logic [31:0] k, input int unsigned width);
    logic [31:0] s;
    s = k >> 1;
    if (k[0]) s = s ^ taps_for(width);
    return s;
  endfunction

  function automatic bit cfg_ok(input int unsigned width, input logic [31:0] seed);
    return ((width == 8) || (width == 16) || (width == 32)) && (seed != 32'h0);
  endfunction

endpackage

// File: rtl/xor_lfsr.sv
// Key register with load, zero-key substitution and one LFSR step per accepted word.
module xor_lfsr
  import xor_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = 'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_in,
  input  logic             step_en,
  output logic [WIDTH-1:0] key_q
);

  logic [WIDTH-1:0] key_reg;
  logic [WIDTH-1:0] key_step_next;
  logic [WIDTH-1:0] key_load_next;

  assign key_step_next = WIDTH'(lfsr_step(32'(key_reg), WIDTH));
  // An all-zero key would lock the LFSR, so it is replaced by the seed.
  assign key_load_next = (key_in == '0) ? SEED : key_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg <= SEED;
    end else if (key_load) begin
      key_reg <= key_load_next;
    end else if (step_en) begin
      key_reg <= key_step_next;
    end
  end

  assign key_q = key_reg;

endmodule

// File: rtl/xor_keystream_unit.sv
// Streaming XOR with key register and 2-entry skid buffer.
// Define XOR_LFSR_EN to advance the key by an LFSR step on every accepted word.
module xor_keystream_unit
  import xor_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = 'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (!cfg_ok(WIDTH, 32'(SEED))) begin : g_bad_cfg
    $error("xor_keystream_unit: WIDTH must be 8/16/32 and SEED non-zero");
  end

  buf_state_e       state_reg;
  logic [WIDTH-1:0] head_reg;
  logic [WIDTH-1:0] tail_reg;
  logic [WIDTH-1:0] key_q;
  logic [WIDTH-1:0] result;
  logic             accept;
  logic             drain;

  assign in_ready  = (state_reg != TWO);
  assign out_valid = (state_reg != EMPTY);
  assign out_data  = head_reg;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_xor
    assign result[gi] = in_data[gi] ^ key_q[gi];
  end

`ifdef XOR_LFSR_EN
  xor_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_key (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_load (key_load),
    .key_in   (key_in),
    .step_en  (accept),
    .key_q    (key_q)
  );
`else
  logic [WIDTH-1:0] key_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg <= SEED;
    end else if (key_load) begin
      key_reg <= key_in;
    end
  end

  assign key_q = key_reg;
`endif

  // head_reg is always the oldest word; tail_reg only matters in TWO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            head_reg  <= result;
            state_reg <= ONE;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            tail_reg  <= result;
            state_reg <= TWO;
          end else if (!accept && drain) begin
            state_reg <= EMPTY;
          end else if (accept && drain) begin
            head_reg <= result;
          end
        end
        TWO: begin
          if (drain) begin
            head_reg  <= tail_reg;
            state_reg <= ONE;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_keystream_unit.sv
// Directed self-checking bench for xor_keystream_unit (WIDTH=8, SEED=0xA5).
module tb_xor_keystream_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_load = 1'b0;
  logic [7:0] key_in = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  xor_keystream_unit #(.WIDTH(8), .SEED(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    key_load = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_key(input logic [7:0] k);
    @(negedge clk);
    key_load = 1'b1;
    key_in = k;
    @(posedge clk);
    #1 key_load = 1'b0;
  endtask

  // One word through an empty buffer with out_ready high; result sampled at the next negedge.
  task automatic send(input logic [7:0] d, input logic kl, input logic [7:0] kin,
                      output logic [7:0] got, output logic got_v);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    key_load = kl;
    key_in = kin;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    key_load = 1'b0;
    @(negedge clk);
    got = out_data;
    got_v = out_valid;
    $display("txn in=%h key_load=%0d key_in=%h -> out_valid=%0d out=%h", d, kl, kin, got_v, got);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_xor();
    logic [7:0] got;
    logic       gv;
`ifdef XOR_LFSR_EN
    logic [7:0] din_a [3] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] exp_a [3] = '{8'hA5, 8'hEA, 8'h75};
    logic [7:0] din_b [3] = '{8'hA5, 8'hEA, 8'h75};
    logic [7:0] exp_b [3] = '{8'h00, 8'h00, 8'h00};
    apply_reset();
`else
    logic [7:0] din_a [3] = '{8'h3C, 8'hFF, 8'h00};
    logic [7:0] exp_a [3] = '{8'h33, 8'hF0, 8'h0F};
    logic [7:0] din_b [3] = '{8'h3C, 8'hFF, 8'h00};
    logic [7:0] exp_b [3] = '{8'h33, 8'hF0, 8'h0F};
    apply_reset();
    load_key(8'h0F);
`endif
    for (int i = 0; i < 3; i++) begin
      send(din_a[i], 1'b0, 8'h00, got, gv);
      total_cnt++; if (gv !== 1'b1 || got !== exp_a[i]) $display("FAIL xor_a%0d: got v=%b %h want v=1 %h", i, gv, got, exp_a[i]); else pass_cnt++;
    end
    apply_reset();
`ifndef XOR_LFSR_EN
    load_key(8'h0F);
`endif
    for (int i = 0; i < 3; i++) begin
      send(din_b[i], 1'b0, 8'h00, got, gv);
      total_cnt++; if (gv !== 1'b1 || got !== exp_b[i]) $display("FAIL xor_b%0d: got v=%b %h want v=1 %h", i, gv, got, exp_b[i]); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
`ifdef XOR_LFSR_EN
    logic [7:0] exp [3] = '{8'hB4, 8'hC8, 8'h46};
    apply_reset();
`else
    logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
    apply_reset();
    load_key(8'h00);
`endif
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h11;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after_1: got %b want 1", in_ready); else pass_cnt++;
    in_data = 8'h22;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_after_2: got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1 || out_data !== exp[0]) $display("FAIL bp_head: got v=%b %h want v=1 %h", out_valid, out_data, exp[0]); else pass_cnt++;
    in_data = 8'h33;
    @(negedge clk);
    $display("txn held in=33 in_ready=%0d out_valid=%0d out=%h", in_ready, out_valid, out_data);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_held_ready: got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1 || out_data !== exp[0]) $display("FAIL bp_stable: got v=%b %h want v=1 %h", out_valid, out_data, exp[0]); else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    $display("txn drain out_valid=%0d out=%h in_ready=%0d", out_valid, out_data, in_ready);
    total_cnt++; if (out_valid !== 1'b1 || out_data !== exp[1]) $display("FAIL bp_out1: got v=%b %h want v=1 %h", out_valid, out_data, exp[1]); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_reopen: got %b want 1", in_ready); else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    $display("txn drain out_valid=%0d out=%h", out_valid, out_data);
    total_cnt++; if (out_valid !== 1'b1 || out_data !== exp[2]) $display("FAIL bp_out2: got v=%b %h want v=1 %h", out_valid, out_data, exp[2]); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_simul_load();
    logic [7:0] got;
    logic       gv;
`ifdef XOR_LFSR_EN
    logic [7:0] exp_third = 8'h1E;
`else
    logic [7:0] exp_third = 8'h3C;
`endif
    apply_reset();
    send(8'h00, 1'b1, 8'h3C, got, gv);
    total_cnt++; if (gv !== 1'b1 || got !== 8'hA5) $display("FAIL simul_old_key: got v=%b %h want v=1 a5", gv, got); else pass_cnt++;
    send(8'h00, 1'b0, 8'h00, got, gv);
    total_cnt++; if (got !== 8'h3C) $display("FAIL simul_new_key: got %h want 3c", got); else pass_cnt++;
    send(8'h00, 1'b0, 8'h00, got, gv);
    total_cnt++; if (got !== exp_third) $display("FAIL simul_after: got %h want %h", got, exp_third); else pass_cnt++;
  endtask

  task automatic test_zero_key();
    logic [7:0] got;
    logic       gv;
`ifdef XOR_LFSR_EN
    logic [7:0] exp = 8'hFF;
`else
    logic [7:0] exp = 8'h5A;
`endif
    apply_reset();
    load_key(8'h77);
    load_key(8'h00);
    send(8'h5A, 1'b0, 8'h00, got, gv);
    total_cnt++; if (gv !== 1'b1 || got !== exp) $display("FAIL zero_key: got v=%b %h want v=1 %h", gv, got, exp); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    logic       gv;
    apply_reset();
    load_key(8'h3C);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h01;
    @(negedge clk);
    in_data = 8'h02;
    @(negedge clk);
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL mid_full: got v=%b r=%b want v=1 r=0", out_valid, in_ready); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", in_ready); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_no_partial: got %b want 0", out_valid); else pass_cnt++;
    send(8'h00, 1'b0, 8'h00, got, gv);
    total_cnt++; if (gv !== 1'b1 || got !== 8'hA5) $display("FAIL mid_seed: got v=%b %h want v=1 a5", gv, got); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_xor();
    test_back_to_back();
    test_simul_load();
    test_zero_key();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
